image_write_arbiter: RTL and testbench
======================================

// Module: image_write_arbiter
// PURPOSE
//   Frame-granular arbiter and sequencer in front of the BMP image writer.
//   Two pixel sources (A: original pass-through, B: processed) share the
//   writer's single RGB888 input. A whole frame is granted to one source;
//   its pixels are streamed in raster order as hsync-qualified beats.
//   Frame boundaries, grants and a post-frame flush gap are enforced.
// PARAMETERS
//   WIDTH   768  pixels per row
//   HEIGHT  512  rows per frame
//   GAP     4    idle cycles after a frame before the next grant (GAP>=1)
// PORTS
//   HCLK        in   1   clock, all logic on rising edge
//   HRESET      in   1   synchronous reset, active-high
//   req_a       in   1   source A requests a frame (level)
//   req_b       in   1   source B requests a frame (level)
//   a_valid     in   1   source A pixel valid
//   a_ready     out  1   source A pixel accepted when a_valid&&a_ready
//   a_r/a_g/a_b in   8   source A pixel R/G/B
//   b_valid     in   1   source B pixel valid
//   b_ready     out  1   source B pixel accepted when b_valid&&b_ready
//   b_r/b_g/b_b in   8   source B pixel R/G/B
//   hsync       out  1   one writer beat this cycle
//   DATA_WRITE_R0/G0/B0 out 8 pixel to writer, valid when hsync=1
//   grant_a     out  1   frame currently owned by A
//   grant_b     out  1   frame currently owned by B
//   busy        out  1   state != IDLE
//   frame_done  out  1   one-cycle pulse, coincident with last beat's hsync
//   frame_cnt   out  16  completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//   Interface: single clock HCLK; HRESET synchronous, active-high.
//   Reset: all outputs 0, state IDLE, col=row=0, RR pointer favours A.
//   FSM: IDLE -> STREAM -> DRAIN -> IDLE.
//   - IDLE: req sampled only here. Only one req high -> grant it.
//     Both high -> grant the source not granted last (after reset: A).
//     Neither high -> stay. Grant asserts the cycle after the decision.
//   - STREAM: ready = 1 for granted source only; other ready = 0.
//     Beat accepted on valid&&ready. col increments per beat.
//     col==WIDTH-1 -> col=0, row++. valid low = stall; no beat, no hsync.
//     req deassertion during STREAM is ignored; the frame always completes.
//   - Last beat (col==WIDTH-1, row==HEIGHT-1) accepted -> DRAIN.
//     ready drops the next cycle. col/row clear; RR pointer updates.
//   - DRAIN: grant_x held; exactly GAP cycles, then IDLE.
//     No beats accepted, both ready = 0.
//   Output stage: one register stage. hsync and DATA_WRITE_* are valid
//     exactly 1 cycle after the accepting edge, so pixel latency = 1.
//     DATA_WRITE_* hold their last value when hsync=0.
//   frame_done pulses with the final beat's hsync (first DRAIN cycle).
//     frame_cnt increments on the same edge.
//   Beats per frame = WIDTH*HEIGHT exactly, never more.
//   Reset mid-frame: immediate return to reset state; partial frame
//     discarded; no frame_done.
// TESTING  (WIDTH=4, HEIGHT=2, GAP=2 unless stated)
//   1 req_a=1, a_valid=1 continuously, pixels R=0..7
//     -> 8 hsync beats R=0..7 on consecutive cycles.
//     -> frame_done on beat 8, frame_cnt=1, 2 DRAIN cycles, then busy=0.
//   2 req_a=req_b=1 from reset, held high
//     -> frames granted A,B,A,B; grant_a/grant_b never both 1.
//     -> b_ready=0 throughout every A frame.
//   3 a_valid toggles 1,0,1,0 during STREAM
//     -> hsync only in the cycle after each valid=1 cycle.
//     -> 8 beats total, data order preserved.
//   4 req_a dropped after beat 3
//     -> frame still completes all 8 beats, then IDLE.
//   5 HRESET=1 at beat 5 of a frame
//     -> next cycle all outputs 0.
//     -> new req_b frame starts at col=0,row=0, frame_cnt stays 0.
//   6 frame_cnt preloaded via force at 0xFFFF, one frame -> frame_cnt=0.

Source files
------------

// File: rtl/image_write_arbiter.sv
// image_write_arbiter: frame-granular round-robin arbiter streaming one source's pixels to the BMP writer.
module image_write_arbiter #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int GAP    = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [7:0]  a_r,
  input  logic [7:0]  a_g,
  input  logic [7:0]  a_b,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [7:0]  b_r,
  input  logic [7:0]  b_g,
  input  logic [7:0]  b_b,
  output logic        hsync,
  output logic [7:0]  DATA_WRITE_R0,
  output logic [7:0]  DATA_WRITE_G0,
  output logic [7:0]  DATA_WRITE_B0,
  output logic        grant_a,
  output logic        grant_b,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [GW-1:0]   r_gap;
  logic            r_pref_b;
  logic            w_acc;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_pick_b;
  logic [23:0]     w_pix;
  assign a_ready    = r_state == STREAM && grant_a;
  assign b_ready    = r_state == STREAM && grant_b;
  assign busy       = r_state != IDLE;
  assign w_acc      = (a_valid && a_ready) || (b_valid && b_ready);
  assign w_pix      = grant_b ? {b_r, b_g, b_b} : {a_r, a_g, a_b};
  assign w_last_col = r_col == CW'(WIDTH - 1);
  assign w_last_row = r_row == RW'(HEIGHT - 1);
  // with both requesting, r_pref_b names the source that did not own the last frame
  assign w_pick_b   = req_b && (!req_a || r_pref_b);
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_gap         <= '0;
      r_pref_b      <= 1'b0;
      hsync         <= 1'b0;
      DATA_WRITE_R0 <= '0;
      DATA_WRITE_G0 <= '0;
      DATA_WRITE_B0 <= '0;
      grant_a       <= 1'b0;
      grant_b       <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      hsync      <= w_acc;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: if (req_a || req_b) begin
          r_state <= STREAM;
          grant_a <= !w_pick_b;
          grant_b <= w_pick_b;
        end
        STREAM: if (w_acc) begin
          {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0} <= w_pix;
          r_col <= w_last_col ? '0 : r_col + 1'b1;
          r_row <= w_last_col ? r_row + 1'b1 : r_row;
          if (w_last_col && w_last_row) begin
            r_state    <= DRAIN;
            r_row      <= '0;
            r_gap      <= '0;
            r_pref_b   <= grant_a;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end
        end
        DRAIN: if (r_gap == GW'(GAP - 1)) begin
          r_state <= IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
        end else begin
          r_gap <= r_gap + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_write_arbiter.sv
// tb_image_write_arbiter: scoreboard bench for the frame arbiter at WIDTH=4, HEIGHT=2, GAP=2.
module tb_image_write_arbiter;
  localparam int WIDTH = 4, HEIGHT = 2, GAP = 2, NPIX = WIDTH * HEIGHT;
  logic HCLK = 0, HRESET = 1, req_a = 0, req_b = 0;
  logic a_valid = 0, b_valid = 0, a_ready, b_ready, hsync;
  logic [7:0] a_r = 0, a_g = 0, a_b = 0, b_r = 0, b_g = 0, b_b = 0;
  logic [7:0] DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
  logic grant_a, grant_b, busy, frame_done;
  logic [15:0] frame_cnt;
  int total = 0, bad = 0, ia = 0, ib = 0, beats = 0;
  bit a_en = 0, b_en = 0, a_tog = 0, hs_a, hs_b;
  logic [23:0] exp_q[$];
  logic [23:0] e;

  image_write_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .GAP(GAP)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_a(req_a), .req_b(req_b),
    .a_valid(a_valid), .a_ready(a_ready), .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .b_valid(b_valid), .b_ready(b_ready), .b_r(b_r), .b_g(b_g), .b_b(b_b),
    .hsync(hsync), .DATA_WRITE_R0(DATA_WRITE_R0), .DATA_WRITE_G0(DATA_WRITE_G0),
    .DATA_WRITE_B0(DATA_WRITE_B0), .grant_a(grant_a), .grant_b(grant_b),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt));

  initial forever #5 HCLK = ~HCLK;

  function automatic logic [23:0] pix(input bit src, input int k);
    logic [7:0] v;
    v = 8'(k);
    return src ? {8'hA0 + v, v ^ 8'h55, 8'hF0 - v} : {v, 8'h40 + v, 8'h80 + v};
  endfunction

  // source models: advance to the next pixel only after a handshake
  initial forever begin
    @(negedge HCLK);
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    @(posedge HCLK);
    #1;
    if (hs_a) ia++;
    if (hs_b) ib++;
    {a_r, a_g, a_b} = pix(0, ia);
    {b_r, b_g, b_b} = pix(1, ib);
    a_valid = a_tog ? !a_valid : a_en;
    b_valid = b_en;
  end

  // scoreboard and grant invariants
  initial forever begin
    @(negedge HCLK);
    if (!HRESET) begin
      total++;
      if ((grant_a && grant_b) || (grant_a && b_ready) || (grant_b && a_ready)) begin
        bad++;
        $display("FAIL grant_excl ga=%b gb=%b ar=%b br=%b", grant_a, grant_b, a_ready, b_ready);
      end
      if (hsync) begin
        beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat got=%h expected none", {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0});
        end else begin
          e = exp_q.pop_front();
          if ({DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0} !== e) begin
            bad++;
            $display("FAIL pixel got=%h expected=%h", {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0}, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge HCLK);
    HRESET = 1; req_a = 0; req_b = 0; a_en = 0; b_en = 0; a_tog = 0;
    @(negedge HCLK);
    @(negedge HCLK);
    ia = 0; ib = 0; exp_q.delete(); beats = 0;
    @(negedge HCLK);
    HRESET = 0;
  endtask

  task automatic push_frame(input bit src, input int base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(pix(src, base + k));
  endtask

  task automatic wait_done(output bit got);
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!frame_done && n < 200);
    got = frame_done;
  endtask

  task automatic test_reset;
    @(negedge HCLK);
    HRESET = 1;
    @(negedge HCLK);
    total++;
    if ({hsync, frame_done, grant_a, grant_b, busy, a_ready, b_ready, DATA_WRITE_R0,
         DATA_WRITE_G0, DATA_WRITE_B0, frame_cnt} !== 47'd0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b ga=%b gb=%b cnt=%h expected all 0", busy, grant_a, grant_b, frame_cnt);
    end
    HRESET = 0;
    repeat (2) @(negedge HCLK);
    total++;
    if (busy !== 0 || grant_a !== 0 || grant_b !== 0) begin
      bad++;
      $display("FAIL idle_no_req busy=%b ga=%b gb=%b expected 0", busy, grant_a, grant_b);
    end
  endtask

  task automatic test_single_frame;
    int n = 0;
    do_reset();
    req_a = 1; a_en = 1;
    push_frame(0, 0, NPIX);
    @(negedge HCLK);
    req_a = 0;
    while (!hsync && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    total++;
    if (!hsync) begin
      bad++;
      $display("FAIL first_beat timeout hsync=%b expected 1", hsync);
    end
    for (int k = 0; k < NPIX; k++) begin
      if (k > 0) @(negedge HCLK);
      total++;
      if ({hsync, frame_done} !== {1'b1, k == NPIX - 1}) begin
        bad++;
        $display("FAIL consecutive beat=%0d hs_fd=%b%b expected 1%b", k, hsync, frame_done, k == NPIX - 1);
      end
    end
    total++;
    if (frame_cnt !== 16'd1 || busy !== 1) begin
      bad++;
      $display("FAIL done_count cnt=%0d busy=%b expected 1 1", frame_cnt, busy);
    end
    @(negedge HCLK);
    total++;
    if (busy !== 1 || grant_a !== 1 || a_ready !== 0 || hsync !== 0) begin
      bad++;
      $display("FAIL drain2 busy=%b ga=%b ar=%b hs=%b expected 1 1 0 0", busy, grant_a, a_ready, hsync);
    end
    @(negedge HCLK);
    total++;
    if (busy !== 0 || grant_a !== 0) begin
      bad++;
      $display("FAIL after_drain busy=%b ga=%b expected 0 0", busy, grant_a);
    end
    @(negedge HCLK);
    total++;
    if (beats !== NPIX || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL single_beats beats=%0d left=%0d expected %0d 0", beats, exp_q.size(), NPIX);
    end
  endtask

  task automatic test_round_robin;
    bit got;
    do_reset();
    req_a = 1; req_b = 1; a_en = 1; b_en = 1;
    push_frame(0, 0, NPIX);
    push_frame(1, 0, NPIX);
    push_frame(0, NPIX, NPIX);
    push_frame(1, NPIX, NPIX);
    for (int f = 0; f < 4; f++) begin
      wait_done(got);
      total++;
      if (!got) begin
        bad++;
        $display("FAIL rr_timeout frame=%0d frame_done=%b expected 1", f, frame_done);
      end
      total++;
      if ({grant_a, grant_b} !== ((f % 2) != 0 ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL rr_order frame=%0d ga_gb=%b%b expected %b", f, grant_a, grant_b, (f % 2) != 0 ? 2'b01 : 2'b10);
      end
      if (f == 3) begin
        req_a = 0; req_b = 0;
      end
    end
    repeat (3) @(negedge HCLK);
    total++;
    if (busy !== 0 || frame_cnt !== 16'd4 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL rr_end busy=%b cnt=%0d left=%0d expected 0 4 0", busy, frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_stall;
    bit pv = 0, pr = 0;
    int cnt = 0;
    do_reset();
    req_a = 1; a_tog = 1;
    push_frame(0, 0, NPIX);
    for (int n = 0; n < 60; n++) begin
      @(negedge HCLK);
      if (grant_a) req_a = 0;
      if (n > 0) begin
        total++;
        if (hsync !== (pv && pr)) begin
          bad++;
          $display("FAIL stall_hsync cycle=%0d hs=%b expected %b", n, hsync, pv && pr);
        end
      end
      pv = a_valid;
      pr = a_ready;
      if (hsync) cnt++;
      if (frame_done) break;
    end
    a_tog = 0;
    total++;
    if (cnt !== NPIX || frame_done !== 1) begin
      bad++;
      $display("FAIL stall_beats beats=%0d done=%b expected %0d 1", cnt, frame_done, NPIX);
    end
    repeat (4) @(negedge HCLK);
    total++;
    if (exp_q.size() !== 0 || busy !== 0) begin
      bad++;
      $display("FAIL stall_end left=%0d busy=%b expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_req_drop;
    int cnt = 0;
    do_reset();
    req_a = 1; a_en = 1;
    push_frame(0, 0, NPIX);
    for (int n = 0; n < 60; n++) begin
      @(negedge HCLK);
      if (hsync) cnt++;
      if (cnt == 3) req_a = 0;
      if (frame_done) break;
    end
    total++;
    if (cnt !== NPIX || frame_done !== 1) begin
      bad++;
      $display("FAIL drop_beats beats=%0d done=%b expected %0d 1", cnt, frame_done, NPIX);
    end
    repeat (4) @(negedge HCLK);
    total++;
    if (busy !== 0 || grant_a !== 0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL drop_idle busy=%b ga=%b left=%0d expected 0 0 0", busy, grant_a, exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    int cnt = 0, n = 0;
    bit got;
    do_reset();
    req_a = 1; a_en = 1;
    push_frame(0, 0, 5);
    while (cnt < 5 && n < 60) begin
      @(negedge HCLK);
      n++;
      if (hsync) cnt++;
    end
    HRESET = 1; req_a = 0; a_en = 0;
    @(negedge HCLK);
    total++;
    if ({hsync, frame_done, grant_a, grant_b, busy, a_ready, b_ready, DATA_WRITE_R0,
         DATA_WRITE_G0, DATA_WRITE_B0, frame_cnt} !== 47'd0) begin
      bad++;
      $display("FAIL midreset_outputs hs=%b ga=%b busy=%b data=%h cnt=%h expected all 0", hsync, grant_a, busy,
               {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0}, frame_cnt);
    end
    total++;
    if (exp_q.size() !== 0 || cnt !== 5) begin
      bad++;
      $display("FAIL midreset_partial beats=%0d left=%0d expected 5 0", cnt, exp_q.size());
    end
    ia = 0; ib = 0; beats = 0;
    HRESET = 0; req_b = 1; b_en = 1;
    push_frame(1, 0, NPIX);
    @(negedge HCLK);
    req_b = 0;
    wait_done(got);
    total++;
    if (!got || frame_cnt !== 16'd1 || grant_b !== 1) begin
      bad++;
      $display("FAIL midreset_newframe done=%b cnt=%0d gb=%b expected 1 1 1", got, frame_cnt, grant_b);
    end
    repeat (3) @(negedge HCLK);
    total++;
    if (beats !== NPIX || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL midreset_beats beats=%0d left=%0d expected %0d 0", beats, exp_q.size(), NPIX);
    end
  endtask

  task automatic test_wrap;
    bit got;
    do_reset();
    force dut.frame_cnt = 16'hFFFF;
    @(negedge HCLK);
    release dut.frame_cnt;
    @(negedge HCLK);
    total++;
    if (frame_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload cnt=%h expected ffff", frame_cnt);
    end
    req_a = 1; a_en = 1;
    push_frame(0, 0, NPIX);
    @(negedge HCLK);
    req_a = 0;
    wait_done(got);
    total++;
    if (!got || frame_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL wrap cnt=%h done=%b expected 0000 1", frame_cnt, got);
    end
    repeat (3) @(negedge HCLK);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
    test_req_drop();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
